// File: rtl/tone_mixer.sv
// tone_mixer: square-wave tone generator and mixer.
//
// CH independent channels each produce a square wave whose half-period is
// set by a per-channel divider. The channels share one effective volume
// level, are summed and rescaled, and are presented as one registered
// signed sample on both stereo outputs. The user volume moves in single
// steps on up/down pulses; the applied volume glides toward the user
// volume (or toward silence while muted) one level every RAMP_CYC cycles
// so that volume changes and mute do not produce audible clicks.
module tone_mixer #(
  parameter int CH       = 2,
  parameter int DIV_W    = 22,
  parameter int SAMPLE_W = 16,
  parameter int VOL_BITS = 3,
  parameter int VOL_INIT = 4,
  parameter int RAMP_CYC = 250000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CH*DIV_W-1:0]        freq_div,
  input  logic                       vol_up,
  input  logic                       vol_down,
  input  logic                       mute,
  output logic signed [SAMPLE_W-1:0] audio_left,
  output logic signed [SAMPLE_W-1:0] audio_right,
  output logic [VOL_BITS-1:0]        volume,
  output logic [VOL_BITS-1:0]        eff_volume,
  output logic                       ramping
);

  // Sum of CH full-scale contributions needs log2(CH) extra bits; the
  // final arithmetic shift brings it back to SAMPLE_W without overflow.
  localparam int LOG_CH  = $clog2(CH);
  localparam int MIX_W   = SAMPLE_W + LOG_CH;
  // One volume level is worth 2^STEP_SH sample units, so the top level
  // stays just below positive full scale.
  localparam int STEP_SH = SAMPLE_W - 1 - VOL_BITS;
  // Ramp counter wide enough for 0..RAMP_CYC-1 (at least one bit).
  localparam int RC_W    = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;

  localparam logic [VOL_BITS-1:0] VOL_MAX   = '1;
  localparam logic [VOL_BITS-1:0] VOL_RESET = VOL_BITS'(VOL_INIT);
  localparam logic [RC_W-1:0]     RAMP_LAST = RC_W'(RAMP_CYC - 1);

  // ---------------------------------------------------------------------
  // Channel oscillators
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0]        freq_ch   [CH];
  logic [DIV_W-1:0]        freq_prev [CH];
  logic [DIV_W-1:0]        cnt       [CH];
  logic                    phase     [CH];

  // Unpack the flat divider bus into one word per channel.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a value on every
    // path (here via the loop covering all channels) so no latch is inferred.
    for (int i = 0; i < CH; i++) begin
      freq_ch[i] = freq_div[i*DIV_W +: DIV_W];
    end
  end

  // Per-channel half-period counter and phase; a divider change restarts
  // the wave at phase 0 so a new note always begins on a clean edge.
  always_ff @(posedge clk) begin
    // NOTE: the counter and divider-copy arrays are reset explicitly; they
    // are a handful of flops, and leaving them unknown would let a stale
    // half-period leak across reset.
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        freq_prev[i] <= '0;
        cnt[i]       <= '0;
        phase[i]     <= 1'b0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        freq_prev[i] <= freq_ch[i];
        if (freq_ch[i] == '0) begin
          cnt[i]   <= '0;
          phase[i] <= 1'b0;
        end else if (freq_ch[i] != freq_prev[i]) begin
          cnt[i]   <= '0;
          phase[i] <= 1'b0;
        end else if (cnt[i] == freq_ch[i] - DIV_W'(1)) begin
          cnt[i]   <= '0;
          phase[i] <= ~phase[i];
        end else begin
          cnt[i]   <= cnt[i] + DIV_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Volume control
  // ---------------------------------------------------------------------
  logic [VOL_BITS-1:0] target;
  logic [RC_W-1:0]     ramp_cnt;

  // Silence is the target while muted; the stored volume is kept so that
  // unmuting returns to the level the user chose.
  assign target  = mute ? '0 : volume;
  assign ramping = (eff_volume != target);

  // User volume: saturating single steps; simultaneous up and down cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      volume <= VOL_RESET;
    end else if (vol_up && !vol_down) begin
      if (volume != VOL_MAX) volume <= volume + VOL_BITS'(1);
    end else if (vol_down && !vol_up) begin
      if (volume != '0) volume <= volume - VOL_BITS'(1);
    end
  end

  // Applied volume glides one level per RAMP_CYC cycles toward the target.
  // A target change mid-ramp keeps the running count and simply steers
  // the next step in the new direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      eff_volume <= VOL_RESET;
      ramp_cnt   <= '0;
    end else if (eff_volume == target) begin
      ramp_cnt   <= '0;
    end else if (ramp_cnt == RAMP_LAST) begin
      ramp_cnt   <= '0;
      if (eff_volume < target) eff_volume <= eff_volume + VOL_BITS'(1);
      else                     eff_volume <= eff_volume - VOL_BITS'(1);
    end else begin
      ramp_cnt   <= ramp_cnt + RC_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Mixer
  // ---------------------------------------------------------------------
  logic signed [MIX_W-1:0] mag;
  logic signed [MIX_W-1:0] mix_sum;
  logic signed [MIX_W-1:0] mix_shift;

  // Sum +/- the shared magnitude for every sounding channel, then rescale.
  // A channel sounds once its divider copy is non-zero, so a new note
  // enters the mix in step with its restarted phase.
  always_comb begin
    mag     = MIX_W'(eff_volume) <<< STEP_SH;
    mix_sum = '0;
    for (int i = 0; i < CH; i++) begin
      if (freq_prev[i] != '0) begin
        mix_sum = phase[i] ? (mix_sum - mag) : (mix_sum + mag);
      end
    end
    mix_shift = mix_sum >>> LOG_CH;
  end

  // Registered output sample, mirrored onto both stereo channels.
  always_ff @(posedge clk) begin
    if (rst) begin
      audio_left  <= '0;
      audio_right <= '0;
    end else begin
      audio_left  <= mix_shift[SAMPLE_W-1:0];
      audio_right <= mix_shift[SAMPLE_W-1:0];
    end
  end

endmodule

// File: tb/tb_tone_mixer.sv
// tb_tone_mixer: directed bench for tone_mixer with CH=2, defaults and
// RAMP_CYC=4. Inputs change and outputs are sampled on the falling edge.
module tb_tone_mixer;

  localparam int CH       = 2;
  localparam int DIV_W    = 22;
  localparam int SAMPLE_W = 16;
  localparam int VOL_BITS = 3;
  localparam int VOL_INIT = 4;
  localparam int RAMP_CYC = 4;

  logic                       clk;
  logic                       rst;
  logic [CH*DIV_W-1:0]        freq_div;
  logic                       vol_up;
  logic                       vol_down;
  logic                       mute;
  logic signed [SAMPLE_W-1:0] audio_left;
  logic signed [SAMPLE_W-1:0] audio_right;
  logic [VOL_BITS-1:0]        volume;
  logic [VOL_BITS-1:0]        eff_volume;
  logic                       ramping;

  int errors = 0;
  int checks = 0;

  tone_mixer #(
    .CH(CH), .DIV_W(DIV_W), .SAMPLE_W(SAMPLE_W), .VOL_BITS(VOL_BITS),
    .VOL_INIT(VOL_INIT), .RAMP_CYC(RAMP_CYC)
  ) dut (
    .clk(clk), .rst(rst), .freq_div(freq_div), .vol_up(vol_up),
    .vol_down(vol_down), .mute(mute), .audio_left(audio_left),
    .audio_right(audio_right), .volume(volume), .eff_volume(eff_volume),
    .ramping(ramping)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Advance until audio_left equals val, at most 20 cycles.
  task automatic wait_audio(input logic signed [SAMPLE_W-1:0] val, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (audio_left === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    freq_div = '0; vol_up = 0; vol_down = 0; mute = 0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (audio_left !== 16'sd0 || audio_right !== 16'sd0) begin
      errors++; $display("FAIL reset_audio: got %0d/%0d expected 0", audio_left, audio_right);
    end
    checks++;
    if (volume !== 3'd4 || eff_volume !== 3'd4) begin
      errors++; $display("FAIL reset_volume: got vol=%0d eff=%0d expected 4/4", volume, eff_volume);
    end
    checks++;
    if (ramping !== 1'b0) begin
      errors++; $display("FAIL reset_ramping: got %0b expected 0", ramping);
    end
    tick(); tick();
    checks++;
    if (audio_left !== 16'sd0) begin
      errors++; $display("FAIL silent_audio: got %0d expected 0", audio_left);
    end
  endtask

  // Tone with half-period 3: find the first negative sample, then expect
  // three negative, three positive, three negative samples.
  task automatic run_tone(input string name, input logic [CH*DIV_W-1:0] f,
                          input logic signed [SAMPLE_W-1:0] amp);
    bit ok;
    logic signed [SAMPLE_W-1:0] exp;
    freq_div = '0;
    do_reset();
    freq_div = f;
    wait_audio(-amp, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL %s_start: got %0d expected %0d within 20 cycles", name, audio_left, -amp);
      return;
    end
    for (int k = 0; k < 9; k++) begin
      exp = (k < 3 || k >= 6) ? -amp : amp;
      checks++;
      if (audio_left !== exp || audio_right !== exp) begin
        errors++; $display("FAIL %s_sample%0d: got %0d/%0d expected %0d", name, k, audio_left, audio_right, exp);
      end
      tick();
    end
  endtask

  task automatic test_single_tone();
    run_tone("tone_ch0", {22'd0, 22'd3}, 16'sd8192);
  endtask

  task automatic test_dual_tone();
    run_tone("tone_both", {22'd3, 22'd3}, 16'sd16384);
  endtask

  task automatic test_volume_up();
    int t [4];
    int v [4];
    int nev;
    logic [VOL_BITS-1:0] prev;
    freq_div = '0; mute = 0;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      vol_up = 1'b1; tick();
    end
    vol_up = 1'b0;
    checks++;
    if (volume !== 3'd7) begin
      errors++; $display("FAIL vol_saturate: got %0d expected 7", volume);
    end
    nev = 0;
    prev = eff_volume;
    for (int c = 0; c < 20; c++) begin
      if (eff_volume !== prev) begin
        if (nev < 4) begin t[nev] = c; v[nev] = int'(eff_volume); end
        nev++;
        prev = eff_volume;
      end
      tick();
    end
    checks++;
    if (nev != 3) begin
      errors++; $display("FAIL up_steps: got %0d steps expected 3", nev);
    end else begin
      checks++;
      if (v[0] != 5 || v[1] != 6 || v[2] != 7) begin
        errors++; $display("FAIL up_values: got %0d,%0d,%0d expected 5,6,7", v[0], v[1], v[2]);
      end
      checks++;
      if (t[0] != 1 || t[1] - t[0] != 4 || t[2] - t[1] != 4) begin
        errors++; $display("FAIL up_timing: got %0d,%0d,%0d expected 1,5,9", t[0], t[1], t[2]);
      end
    end
    checks++;
    if (ramping !== 1'b0) begin
      errors++; $display("FAIL up_ramping_done: got %0b expected 0", ramping);
    end
    vol_up = 1'b1; vol_down = 1'b1; tick();
    vol_up = 1'b0; vol_down = 1'b0;
    checks++;
    if (volume !== 3'd7) begin
      errors++; $display("FAIL up_down_same: got %0d expected 7", volume);
    end
    vol_down = 1'b1; tick(); vol_down = 1'b0;
    checks++;
    if (volume !== 3'd6) begin
      errors++; $display("FAIL vol_down: got %0d expected 6", volume);
    end
  endtask

  task automatic test_mute();
    int t [5];
    int v [5];
    int nev;
    logic [VOL_BITS-1:0] prev;
    freq_div = '0; mute = 0;
    do_reset();
    freq_div = {22'd0, 22'd3};
    tick(); tick();
    mute = 1'b1;
    nev = 0;
    prev = eff_volume;
    for (int c = 0; c < 22; c++) begin
      if (eff_volume !== prev) begin
        if (nev < 5) begin t[nev] = c; v[nev] = int'(eff_volume); end
        nev++;
        prev = eff_volume;
      end
      if (c == 17) begin
        checks++;
        if (audio_left !== 16'sd0) begin
          errors++; $display("FAIL mute_audio: got %0d expected 0", audio_left);
        end
      end
      tick();
    end
    checks++;
    if (nev != 4) begin
      errors++; $display("FAIL mute_steps: got %0d steps expected 4", nev);
    end else begin
      checks++;
      if (v[0] != 3 || v[1] != 2 || v[2] != 1 || v[3] != 0) begin
        errors++; $display("FAIL mute_values: got %0d,%0d,%0d,%0d expected 3,2,1,0", v[0], v[1], v[2], v[3]);
      end
      checks++;
      if (t[0] != 4 || t[1] != 8 || t[2] != 12 || t[3] != 16) begin
        errors++; $display("FAIL mute_timing: got %0d,%0d,%0d,%0d expected 4,8,12,16", t[0], t[1], t[2], t[3]);
      end
    end
    vol_down = 1'b1; tick(); vol_down = 1'b0;
    tick();
    checks++;
    if (volume !== 3'd3 || eff_volume !== 3'd0 || ramping !== 1'b0) begin
      errors++; $display("FAIL muted_vol_down: got vol=%0d eff=%0d ramp=%0b expected 3/0/0", volume, eff_volume, ramping);
    end
    mute = 1'b0;
    nev = 0;
    prev = eff_volume;
    for (int c = 0; c < 20; c++) begin
      if (eff_volume !== prev) begin
        if (nev < 5) begin t[nev] = c; v[nev] = int'(eff_volume); end
        nev++;
        prev = eff_volume;
      end
      tick();
    end
    checks++;
    if (nev != 3 || v[0] != 1 || v[1] != 2 || v[2] != 3) begin
      errors++; $display("FAIL unmute_ramp: got %0d steps ending eff=%0d expected 1,2,3", nev, eff_volume);
    end
    checks++;
    if (eff_volume !== 3'd3 || ramping !== 1'b0) begin
      errors++; $display("FAIL unmute_final: got eff=%0d ramp=%0b expected 3/0", eff_volume, ramping);
    end
  endtask

  task automatic test_freq_change();
    bit ok;
    freq_div = '0; mute = 0;
    do_reset();
    freq_div = {22'd0, 22'd3};
    wait_audio(-16'sd8192, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL chg_start: got %0d expected -8192 within 20 cycles", audio_left);
      return;
    end
    freq_div = {22'd0, 22'd5};
    tick();
    checks++;
    if (audio_left !== -16'sd8192) begin
      errors++; $display("FAIL chg_edge: got %0d expected -8192", audio_left);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (audio_left !== 16'sd8192) begin
        errors++; $display("FAIL chg_phase0_%0d: got %0d expected 8192", k, audio_left);
      end
    end
    tick();
    checks++;
    if (audio_left !== -16'sd8192) begin
      errors++; $display("FAIL chg_toggle: got %0d expected -8192", audio_left);
    end
  endtask

  task automatic test_reset_mid_ramp();
    bit ok;
    freq_div = '0; mute = 0;
    do_reset();
    freq_div = {22'd0, 22'd3};
    mute = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (eff_volume === 3'd2) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL midramp_reach: got eff=%0d expected 2 within 20 cycles", eff_volume);
    end
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (eff_volume !== 3'd4 || volume !== 3'd4 || audio_left !== 16'sd0 || audio_right !== 16'sd0) begin
      errors++; $display("FAIL midramp_reset: got eff=%0d vol=%0d audio=%0d expected 4/4/0", eff_volume, volume, audio_left);
    end
    checks++;
    if (ramping !== 1'b1) begin
      errors++; $display("FAIL midramp_ramping: got %0b expected 1", ramping);
    end
    tick(); tick(); tick();
    checks++;
    if (eff_volume !== 3'd4) begin
      errors++; $display("FAIL midramp_hold: got %0d expected 4", eff_volume);
    end
    tick();
    checks++;
    if (eff_volume !== 3'd3) begin
      errors++; $display("FAIL midramp_first_step: got %0d expected 3", eff_volume);
    end
    mute = 1'b0;
  endtask

  initial begin
    rst = 1'b1; freq_div = '0; vol_up = 0; vol_down = 0; mute = 0;
    test_reset();
    test_single_tone();
    test_dual_tone();
    test_volume_up();
    test_mute();
    test_freq_change();
    test_reset_mid_ramp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_mixer.md
TONE_MIXER -- requirements
Module: tone_mixer

Interface
REQ-001 SHALL have parameter CH, default 2, number of square-wave channels (power of two, 1..8).
REQ-002 SHALL have parameter DIV_W, default 22, width of each channel half-period divider.
REQ-003 SHALL have parameter SAMPLE_W, default 16, width of signed output samples.
REQ-004 SHALL have parameter VOL_BITS, default 3, volume width (levels 0..2^VOL_BITS-1).
REQ-005 SHALL have parameter VOL_INIT, default 4, volume loaded at reset.
REQ-006 SHALL have parameter RAMP_CYC, default 250000, clock cycles per one-level volume step.
REQ-007 SHALL have port clk  input  1  system clock; the single clock of the block.
REQ-008 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-009 SHALL have port freq_div  input  CH*DIV_W  per-channel half-period in clk cycles, channel i at bits [i*DIV_W +: DIV_W]; 0 = silent.
REQ-010 SHALL have port vol_up  input  1  one-cycle pulse, raise volume one level.
REQ-011 SHALL have port vol_down  input  1  one-cycle pulse, lower volume one level.
REQ-012 SHALL have port mute  input  1  level; high = ramp output to silence.
REQ-013 SHALL have port audio_left  output  SAMPLE_W  signed mixed sample, registered.
REQ-014 SHALL have port audio_right  output  SAMPLE_W  identical to audio_left.
REQ-015 SHALL have port volume  output  VOL_BITS  stored user volume.
REQ-016 SHALL have port eff_volume  output  VOL_BITS  volume currently applied to audio.
REQ-017 SHALL have port ramping  output  1  high while eff_volume != target.

Function
REQ-018 Per channel: counter cnt, phase bit; freq_div_i==0 -> cnt=0, phase=0, contribution 0.
REQ-019 freq_div_i differing from its value last cycle (registered copy) -> cnt<=0, phase<=0 that cycle (phase restart).
REQ-020 Otherwise cnt==freq_div_i-1 -> cnt<=0, phase toggles; else cnt+1; full period = 2*freq_div_i cycles; freq_div_i==1 toggles every cycle.
REQ-021 Contribution: phase 0 -> +eff_volume*STEP, phase 1 -> -eff_volume*STEP, STEP = 2^(SAMPLE_W-1-VOL_BITS).
REQ-022 Mix = signed sum of all contributions (width SAMPLE_W+log2(CH)), arithmetic shift right by log2(CH); no overflow possible, no saturation logic.
REQ-023 audio_left/right registered from current phase/eff_volume; latency 1 cycle after any phase or eff_volume change.
REQ-024 vol_up: volume+1, saturate at 2^VOL_BITS-1; vol_down: volume-1, saturate at 0; both same cycle -> no change.
REQ-025 volume updates regardless of mute.
REQ-026 target = mute ? 0 : volume.
REQ-027 eff_volume != target -> ramp_cnt counts; at ramp_cnt==RAMP_CYC-1, eff_volume steps one level toward target, ramp_cnt<=0.
REQ-028 eff_volume == target -> ramp_cnt held 0; target change mid-ramp -> continue from current eff_volume toward new target, ramp_cnt not cleared.
REQ-029 ramping = (eff_volume != target), combinational from registered state.

Reset
REQ-030 rst sampled high -> next edge: volume=VOL_INIT, eff_volume=VOL_INIT, all cnt/phase/ramp_cnt=0, registered freq_div copy=0, audio_left=audio_right=0.
REQ-031 Reset mid-ramp or mid-period SHALL abandon the operation with no residual state; mute high at release -> ramp down begins from VOL_INIT.

Verification (CH=2, defaults, RAMP_CYC=4)
REQ-032 Reset, freq_div=0 -> audio 0, volume 4, eff_volume 4, ramping 0.
REQ-033 ch0=3, ch1=0, vol 4 -> audio +8192 x3 cycles, -8192 x3, repeating; ch1=3 also -> +/-16384.
REQ-034 Four vol_up pulses -> volume 7 (saturated), eff_volume 5,6,7 at 4-cycle steps; vol_up+vol_down same cycle -> no change.
REQ-035 mute at vol 4 -> eff_volume 3,2,1,0 at 4-cycle steps, audio 0 after 16 cycles; vol_down while muted -> volume 3, eff 0; unmute -> ramps to 3.
REQ-036 ch0 changed 3->5 mid half-period -> phase 0 restart, next toggle 5 cycles later.
REQ-037 rst during ramp (eff 2, target 0) -> eff_volume 4, volume 4, audio 0 next cycle.
